// File: rtl/array_pair_buffer_pkg.sv
// Shared definitions for the array pair buffer.
//   SEL_A / SEL_B : response selector values for operand array A and B
//   state_t       : job state machine encoding
//   tag_width()   : slot tag width for a given slot count
package array_pair_buffer_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int tag_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/array_pair_buffer_if.sv
// Job control, slot allocation, read response and pair output bundle.
//   master : requester / response source / adder side (drives start, alloc, rsp_*)
//   slave  : array_pair_buffer side (drives alloc_ready, alloc_tag, pair outputs, done, err)
interface array_pair_buffer_if #(
    parameter int CACHE_WIDTH = 512,
    parameter int TAG_WIDTH   = 3,
    parameter int CNT_WIDTH   = 32
);
    logic                   start;
    logic [CNT_WIDTH-1:0]   num_lines;
    logic                   alloc_ready;
    logic                   alloc;
    logic [TAG_WIDTH-1:0]   alloc_tag;
    logic                   rsp_valid;
    logic                   rsp_sel;
    logic [TAG_WIDTH-1:0]   rsp_tag;
    logic [CACHE_WIDTH-1:0] rsp_data;
    logic                   enable;
    logic [CACHE_WIDTH-1:0] array1;
    logic [CACHE_WIDTH-1:0] array2;
    logic [CNT_WIDTH-1:0]   out_idx;
    logic                   done;
    logic                   err;

    modport master (
        output start, num_lines, alloc, rsp_valid, rsp_sel, rsp_tag, rsp_data,
        input  alloc_ready, alloc_tag, enable, array1, array2, out_idx, done, err
    );

    modport slave (
        input  start, num_lines, alloc, rsp_valid, rsp_sel, rsp_tag, rsp_data,
        output alloc_ready, alloc_tag, enable, array1, array2, out_idx, done, err
    );
endinterface

// File: rtl/array_pair_buffer_line_slot_ram.sv
// line_slot_ram: DEPTH x WIDTH line store, one synchronous write port and one
// registered read port.
//   clk, rst          : clock, synchronous reset (clears only the read register)
//   wr_en/addr/data   : write port
//   rd_en/addr        : read request; rd_data updates the cycle after rd_en
//   rd_data           : read register, holds its value while rd_en is low
module line_slot_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 512,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // The read register doubles as the pair output register, so it is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/array_pair_buffer.sv
// array_pair_buffer: collects out-of-order A/B read responses into reorder
// slots and emits each line pair in line order as a one-cycle enable pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of array_pair_buffer_if (job control, slot
//              allocation, responses, pair output, done, err)
module array_pair_buffer
    import array_pair_buffer_pkg::*;
#(
    parameter int CACHE_WIDTH = 512,
    parameter int DEPTH       = 8,
    parameter int TAG_WIDTH   = tag_width(DEPTH),
    parameter int CNT_WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    array_pair_buffer_if.slave bus
);
    localparam logic [TAG_WIDTH:0] OCC_FULL = (TAG_WIDTH+1)'(DEPTH);

    state_t                           state_q, state_d;
    logic [CNT_WIDTH-1:0]             num_lines_q, num_lines_d;
    logic [TAG_WIDTH-1:0]             alloc_ptr_q, alloc_ptr_d;
    logic [TAG_WIDTH-1:0]             head_ptr_q, head_ptr_d;
    logic [CNT_WIDTH-1:0]             alloc_cnt_q, alloc_cnt_d;
    logic [CNT_WIDTH-1:0]             ret_cnt_q, ret_cnt_d;
    logic [TAG_WIDTH:0]               occ_q, occ_d;
    // vld_q[SEL_A] is a_vld, vld_q[SEL_B] is b_vld
    logic [1:0][DEPTH-1:0]            vld_q, vld_d;
    logic                             err_q, err_d;
    logic                             enable_q, enable_d;
    logic [CNT_WIDTH-1:0]             out_idx_q, out_idx_d;
    logic                             alloc_ready_q, alloc_ready_d;

    logic                             alloc_fire;
    logic                             rsp_ok;
    logic                             retire;
    logic [TAG_WIDTH-1:0]             rsp_off;
    logic                             rsp_live;
    logic                             head_full;
    logic [1:0]                       wr_sel;
    logic [CACHE_WIDTH-1:0]           store_rd [2];

    always_comb begin
        state_d     = state_q;
        num_lines_d = num_lines_q;
        alloc_ptr_d = alloc_ptr_q;
        head_ptr_d  = head_ptr_q;
        alloc_cnt_d = alloc_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        occ_d       = occ_q;
        vld_d       = vld_q;
        err_d       = err_q;
        enable_d    = 1'b0;
        out_idx_d   = out_idx_q;
        alloc_fire  = 1'b0;
        rsp_ok      = 1'b0;
        retire      = 1'b0;

        // A slot is live when it lies in the window [head, head+occ) modulo DEPTH.
        rsp_off   = bus.rsp_tag - head_ptr_q;
        rsp_live  = ({1'b0, rsp_off} < occ_q);
        head_full = (occ_q != '0) && vld_q[SEL_A][head_ptr_q] && vld_q[SEL_B][head_ptr_q];

        if (bus.start) begin
            // start flushes everything; same-cycle alloc/response/retire are discarded
            num_lines_d = bus.num_lines;
            alloc_ptr_d = '0;
            head_ptr_d  = '0;
            alloc_cnt_d = '0;
            ret_cnt_d   = '0;
            occ_d       = '0;
            vld_d       = '0;
            err_d       = 1'b0;
            state_d     = (bus.num_lines == '0) ? DONE : RUN;
        end else begin
            if (bus.alloc) begin
                if (alloc_ready_q) begin
                    alloc_fire  = 1'b1;
                    alloc_ptr_d = alloc_ptr_q + TAG_WIDTH'(1);
                    alloc_cnt_d = alloc_cnt_q + CNT_WIDTH'(1);
                end else begin
                    err_d = 1'b1;
                end
            end

            if (bus.rsp_valid) begin
                if (rsp_live && !vld_q[bus.rsp_sel][bus.rsp_tag]) begin
                    rsp_ok = 1'b1;
                    vld_d[bus.rsp_sel][bus.rsp_tag] = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end

            // Uses the registered valid bits: a response landing on the head
            // slot this cycle is only seen next cycle.
            if (state_q == RUN && head_full) begin
                retire                     = 1'b1;
                vld_d[SEL_A][head_ptr_q]   = 1'b0;
                vld_d[SEL_B][head_ptr_q]   = 1'b0;
                head_ptr_d                 = head_ptr_q + TAG_WIDTH'(1);
                ret_cnt_d                  = ret_cnt_q + CNT_WIDTH'(1);
                enable_d                   = 1'b1;
                out_idx_d                  = ret_cnt_q;
            end

            if (alloc_fire && !retire) begin
                occ_d = occ_q + (TAG_WIDTH+1)'(1);
            end else if (!alloc_fire && retire) begin
                occ_d = occ_q - (TAG_WIDTH+1)'(1);
            end

            if (state_q == RUN && ret_cnt_q == num_lines_q) begin
                state_d = DONE;
            end
        end

        alloc_ready_d = (state_d == RUN) && (occ_d < OCC_FULL) && (alloc_cnt_d < num_lines_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            num_lines_q   <= '0;
            alloc_ptr_q   <= '0;
            head_ptr_q    <= '0;
            alloc_cnt_q   <= '0;
            ret_cnt_q     <= '0;
            occ_q         <= '0;
            vld_q         <= '0;
            err_q         <= 1'b0;
            enable_q      <= 1'b0;
            out_idx_q     <= '0;
            alloc_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_lines_q   <= num_lines_d;
            alloc_ptr_q   <= alloc_ptr_d;
            head_ptr_q    <= head_ptr_d;
            alloc_cnt_q   <= alloc_cnt_d;
            ret_cnt_q     <= ret_cnt_d;
            occ_q         <= occ_d;
            vld_q         <= vld_d;
            err_q         <= err_d;
            enable_q      <= enable_d;
            out_idx_q     <= out_idx_d;
            alloc_ready_q <= alloc_ready_d;
        end
    end

    assign wr_sel = {rsp_ok & bus.rsp_sel, rsp_ok & ~bus.rsp_sel};

    // Store 0 holds A lines, store 1 holds B lines. Each read register is
    // loaded on retire and drives the pair output directly.
    for (genvar gi = 0; gi < 2; gi++) begin : g_store
        line_slot_ram #(
            .DEPTH (DEPTH),
            .WIDTH (CACHE_WIDTH),
            .AW    (TAG_WIDTH)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_sel[gi]),
            .wr_addr (bus.rsp_tag),
            .wr_data (bus.rsp_data),
            .rd_en   (retire),
            .rd_addr (head_ptr_q),
            .rd_data (store_rd[gi])
        );
    end

    assign bus.alloc_ready = alloc_ready_q;
    assign bus.alloc_tag   = alloc_ptr_q;
    assign bus.enable      = enable_q;
    assign bus.array1      = store_rd[SEL_A];
    assign bus.array2      = store_rd[SEL_B];
    assign bus.out_idx     = out_idx_q;
    assign bus.done        = (state_q == DONE);
    assign bus.err         = err_q;
endmodule
